// File: rtl/linear_ccd_acq_if.sv
// Frame-RAM port bundle for linear_ccd_acq: 1-cycle-latency read port plus write port.
interface linear_ccd_acq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = 16
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [ACC_W-1:0]  wr_data;
  logic              wr_en;

  modport master (output rd_addr, input rd_data, output wr_addr, output wr_data, output wr_en);
  modport slave  (input rd_addr, output rd_data, input wr_addr, input wr_data, input wr_en);
endinterface

// File: rtl/linear_ccd_acq.sv
// Linear-CCD acquisition core: CCD/CDS/ADC timing, one flush frame, then 2^avg_log2 frames
// accumulated into an external frame RAM by read-modify-write, last frame written averaged.
module linear_ccd_acq #(
  parameter int unsigned PIXELS       = 5340,
  parameter int unsigned PX_CYC       = 8,
  parameter int unsigned TG_CYC       = 16,
  parameter int unsigned CLAMP_PX     = 16,
  parameter int unsigned ADC_LAT      = 0,
  parameter int unsigned ADC_W        = 8,
  parameter int unsigned AVG_LOG2_MAX = 4,
  parameter int unsigned ACC_W        = 16,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             avg_log2,
  input  logic [23:0]            int_cyc,
  output logic                   busy,
  output logic                   f1,
  output logic                   f2,
  output logic                   RB,
  output logic                   clb,
  output logic                   TG,
  output logic                   cdsclk1,
  output logic                   cdsclk2,
  output logic                   adclk,
  input  logic [ADC_W-1:0]       adc_data,
  linear_ccd_acq_if.master       ram,
  output logic                   frame_done
);

  localparam int unsigned NS     = PIXELS + ADC_LAT;
  localparam int unsigned SLOT_W = $clog2(NS + 1);
  localparam int unsigned PH_W   = $clog2(PX_CYC);

  localparam logic [PH_W-1:0]   PhLast  = PH_W'(PX_CYC - 1);
  localparam logic [PH_W-1:0]   PhCap   = PH_W'(PX_CYC - 2);
  localparam logic [PH_W-1:0]   PhHalf  = PH_W'(PX_CYC / 2);
  localparam logic [PH_W-1:0]   PhCds1  = PH_W'(1);
  localparam logic [PH_W-1:0]   PhCds2  = PH_W'(PX_CYC / 2 + 1);
  localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(NS - 1);
  localparam logic [SLOT_W-1:0] SlotLat  = SLOT_W'(ADC_LAT);
  localparam logic [23:0]       TgLast   = 24'(TG_CYC - 1);
  localparam logic [2:0]        AvgMax   = 3'(AVG_LOG2_MAX);

  typedef enum logic [2:0] {StIdle, StTgate, StRead, StInteg, StDone} state_e;

  state_e              state_q, state_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [4:0]          frame_q, frame_d;
  logic [2:0]          avg_q, avg_d;
  logic [23:0]         int_q, int_d;

  logic busy_q, busy_d, f1_q, f1_d, f2_q, f2_d, rb_q, rb_d, clb_q, clb_d, tg_q, tg_d;
  logic cds1_q, cds1_d, cds2_q, cds2_d, adclk_q, adclk_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [ACC_W-1:0]  wr_data_q, wr_data_d;

  logic             frame_last, in_read, acc_q, acc_d;
  logic [ACC_W-1:0] sum;

  // Sequencer next state, then every output decoded from the next state so outputs are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    avg_d   = avg_q;
    int_d   = int_q;
    // Frame index F-1 == 2^avg is the final accumulated frame.
    frame_last = (frame_q == (5'd1 << avg_q));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTgate;
          cnt_d   = '0;
          frame_d = '0;
          avg_d   = (avg_log2 > AvgMax) ? AvgMax : avg_log2;
          int_d   = int_cyc;
        end
      end
      StTgate: begin
        if (cnt_q == TgLast) begin
          state_d = StRead;
          phase_d = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StRead: begin
        if (phase_q == PhLast) begin
          phase_d = '0;
          if (slot_q == SlotLast) begin
            cnt_d = '0;
            if (frame_last) begin
              state_d = StDone;
            end else begin
              frame_d = frame_q + 5'd1;
              state_d = (int_q == 24'd0) ? StTgate : StInteg;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      StInteg: begin
        if (cnt_q == int_q - 24'd1) begin
          state_d = StTgate;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    in_read = (state_d == StRead);
    acc_q   = (frame_q != 5'd0) && (32'(slot_q) >= ADC_LAT);
    acc_d   = (frame_d != 5'd0) && (32'(slot_d) >= ADC_LAT);

    busy_d  = (state_d != StIdle);
    tg_d    = (state_d == StTgate);
    done_d  = (state_d == StDone);
    f1_d    = in_read ? (phase_d < PhHalf) : 1'b1;
    f2_d    = ~f1_d;
    rb_d    = in_read && (phase_d == '0);
    cds1_d  = in_read && (phase_d == PhCds1);
    cds2_d  = in_read && (phase_d == PhCds2);
    adclk_d = in_read && (phase_d >= PhHalf);
    clb_d   = in_read && (32'(slot_d) < CLAMP_PX);

    // Addresses hold through the slot so rd_data stays valid until the capture phase.
    rd_addr_d = in_read ? rd_addr_q : '0;
    if (in_read && acc_d && (phase_d == '0)) rd_addr_d = ADDR_W'(slot_d - SlotLat);
    wr_en_d   = in_read && acc_d && (phase_d == PhLast);
    wr_addr_d = in_read ? wr_addr_q : '0;
    if (wr_en_d) wr_addr_d = ADDR_W'(slot_d - SlotLat);

    // First accumulated frame ignores stale RAM content.
    sum       = ((frame_q == 5'd1) ? '0 : ram.rd_data) + ACC_W'(adc_data);
    wr_data_d = in_read ? wr_data_q : '0;
    if ((state_q == StRead) && acc_q && (phase_q == PhCap)) begin
      wr_data_d = frame_last ? (sum >> avg_q) : sum;
    end
  end

  // State and registered outputs; async reset forces idle clock levels and kills writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= '0;
      slot_q    <= '0;
      frame_q   <= '0;
      avg_q     <= '0;
      int_q     <= '0;
      busy_q    <= 1'b0;
      f1_q      <= 1'b1;
      f2_q      <= 1'b0;
      rb_q      <= 1'b0;
      clb_q     <= 1'b0;
      tg_q      <= 1'b0;
      cds1_q    <= 1'b0;
      cds2_q    <= 1'b0;
      adclk_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      frame_q   <= frame_d;
      avg_q     <= avg_d;
      int_q     <= int_d;
      busy_q    <= busy_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      rb_q      <= rb_d;
      clb_q     <= clb_d;
      tg_q      <= tg_d;
      cds1_q    <= cds1_d;
      cds2_q    <= cds2_d;
      adclk_q   <= adclk_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign f1          = f1_q;
  assign f2          = f2_q;
  assign RB          = rb_q;
  assign clb         = clb_q;
  assign TG          = tg_q;
  assign cdsclk1     = cds1_q;
  assign cdsclk2     = cds2_q;
  assign adclk       = adclk_q;
  assign frame_done  = done_q;
  assign ram.rd_addr = rd_addr_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign ram.wr_en   = wr_en_q;

endmodule
